// File: rtl/audio_pkg.sv
// audio_pkg: constants and types shared by the audio capture/playback blocks.
//   SAMPLE_W    - bits per sample / channel slot
//   ADDR_W      - SRAM word address width
//   dac_state_t - playback controller states
package audio_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned ADDR_W   = 18;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN,
        DONE
    } dac_state_t;

endpackage

// File: rtl/dac_playback_if.sv
// dac_playback_if: SRAM-side handshake of the playback block.
//   ram_rd    - read enable (master -> SRAM)
//   addr_oe   - address bus drive enable; the address itself is a tri-state
//               port on the top so the bus can be shared with capture
//   ram_rdata - read data (SRAM -> master), valid one cycle after the address
interface dac_playback_if #(
    parameter int unsigned SAMPLE_W = audio_pkg::SAMPLE_W
);

    logic                ram_rd;
    logic                addr_oe;
    logic [SAMPLE_W-1:0] ram_rdata;

    modport master (
        output ram_rd,
        output addr_oe,
        input  ram_rdata
    );

    modport slave (
        input  ram_rd,
        input  addr_oe,
        output ram_rdata
    );

endinterface

// File: rtl/dac_playback_i2s_tx_shift.sv
// i2s_tx_shift: MSB-first serialiser for one I2S slot.
//   bclk, rst_n - bit clock, synchronous active-low reset
//   clear       - drop the current word, dacdat 0 from the next cycle
//   load        - start a new word (aborts any word in progress)
//   word        - word to send, captured with load
//   dacdat      - serial data; 0 once all W bits are out
module i2s_tx_shift #(
    parameter int unsigned W = audio_pkg::SAMPLE_W
) (
    input  logic         bclk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] word,
    output logic         dacdat
);

    localparam int unsigned CW = $clog2(W + 1);

    // cnt_q = number of bits already driven; 0 (idle) and W (finished) both hold 0.
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sh_q, sh_d;
    logic          dat_q, dat_d;

    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        dat_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            dat_d = word[W-1];
            sh_d  = {word[W-2:0], 1'b0};
            cnt_d = CW'(1);
        end else if (cnt_q != '0 && cnt_q < CW'(W)) begin
            dat_d = sh_q[W-1];
            sh_d  = {sh_q[W-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge bclk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sh_q  <= '0;
            dat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
            dat_q <= dat_d;
        end
    end

    assign dacdat = dat_q;

endmodule

// File: rtl/dac_playback.sv
// dac_playback: plays 16-bit mono samples from SRAM addresses 0..end_addr to
// the CODEC DAC in I2S format, the same sample in the left and right slots.
//   bclk, rst_n - CODEC bit clock, synchronous active-low reset
//   daclrc      - DAC L/R clock (1 = left slot)
//   play        - level request; 0 stops and releases the address bus
//   end_addr    - last sample address, captured when leaving IDLE
//   addr        - SRAM address, high-Z unless play (and out of reset)
//   dacdat      - serial data to the CODEC
//   done        - high while the whole range has been played
//   sram        - ram_rd / addr_oe / ram_rdata handshake
module dac_playback #(
    parameter int unsigned SAMPLE_W = audio_pkg::SAMPLE_W,
    parameter int unsigned ADDR_W   = audio_pkg::ADDR_W
) (
    input  logic              bclk,
    input  logic              rst_n,
    input  logic              daclrc,
    input  logic              play,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] addr,
    output logic              dacdat,
    output logic              done,
    dac_playback_if.master    sram
);

    import audio_pkg::*;

    dac_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   end_q, end_d;
    logic [SAMPLE_W-1:0] next_q, next_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                last_q, last_d;
    logic                lrc_q;

    logic                lrc_rise, lrc_fall;
    logic                load, clear;
    logic [SAMPLE_W-1:0] load_word;

    always_comb begin
        lrc_rise  = daclrc & ~lrc_q;
        lrc_fall  = ~daclrc & lrc_q;
        state_d   = state_q;
        addr_d    = addr_q;
        end_d     = end_q;
        next_d    = next_q;
        sample_d  = sample_q;
        last_d    = last_q;
        load      = 1'b0;
        clear     = 1'b0;
        load_word = sample_q;

        // Stop wins over any daclrc edge in the same cycle.
        if (!play) begin
            state_d = IDLE;
            addr_d  = '0;
            last_d  = 1'b0;
            clear   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    addr_d  = '0;
                    last_d  = 1'b0;
                    end_d   = end_addr;
                    clear   = 1'b1;
                    state_d = PRIME;
                end
                PRIME: begin
                    // Address 0 has been on the bus since IDLE.
                    next_d  = sram.ram_rdata;
                    clear   = 1'b1;
                    state_d = RUN;
                end
                RUN: begin
                    if (lrc_rise) begin
                        if (last_q) begin
                            clear   = 1'b1;
                            state_d = DONE;
                        end else begin
                            sample_d  = next_q;
                            load      = 1'b1;
                            load_word = next_q;
                            last_d    = (addr_q == end_q);
                            if (addr_q != '1) begin
                                addr_d = addr_q + 1'b1;
                            end
                        end
                    end else if (lrc_fall) begin
                        // Prefetch for the next frame; addr moved at the left edge.
                        next_d    = sram.ram_rdata;
                        load      = 1'b1;
                        load_word = sample_q;
                    end
                end
                DONE: begin
                    clear = 1'b1;
                end
                default: begin
                    clear   = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge bclk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            end_q    <= '0;
            next_q   <= '0;
            sample_q <= '0;
            last_q   <= 1'b0;
            lrc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            end_q    <= end_d;
            next_q   <= next_d;
            sample_q <= sample_d;
            last_q   <= last_d;
            lrc_q    <= daclrc;
        end
    end

    i2s_tx_shift #(
        .W(SAMPLE_W)
    ) u_shift (
        .bclk   (bclk),
        .rst_n  (rst_n),
        .clear  (clear),
        .load   (load),
        .word   (load_word),
        .dacdat (dacdat)
    );

    assign done         = (state_q == DONE);
    assign sram.ram_rd  = (state_q == PRIME) || (state_q == RUN);
    assign sram.addr_oe = play & rst_n;
    assign addr         = sram.addr_oe ? addr_q : 'z;

endmodule

// File: tb/tb_dac_playback.sv
// tb_dac_playback: directed, table-driven checks of dac_playback, plus a
// narrow-address instance for the all-ones end address case.
module tb_dac_playback;

    logic        bclk = 1'b0;
    logic        rst_n;
    logic        daclrc;
    logic        play;
    logic        play2;
    logic [17:0] end_addr;
    logic [2:0]  end_addr2;
    wire  [17:0] addr;
    wire  [2:0]  addr2;
    logic        dacdat, done;
    logic        dacdat2, done2;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [8];

    dac_playback_if #(.SAMPLE_W(16)) sram_if ();
    dac_playback_if #(.SAMPLE_W(16)) sram_if2 ();

    dac_playback #(
        .SAMPLE_W (16),
        .ADDR_W   (18)
    ) dut (
        .bclk     (bclk),
        .rst_n    (rst_n),
        .daclrc   (daclrc),
        .play     (play),
        .end_addr (end_addr),
        .addr     (addr),
        .dacdat   (dacdat),
        .done     (done),
        .sram     (sram_if)
    );

    dac_playback #(
        .SAMPLE_W (16),
        .ADDR_W   (3)
    ) dut_small (
        .bclk     (bclk),
        .rst_n    (rst_n),
        .daclrc   (daclrc),
        .play     (play2),
        .end_addr (end_addr2),
        .addr     (addr2),
        .dacdat   (dacdat2),
        .done     (done2),
        .sram     (sram_if2)
    );

    always #5 bclk = ~bclk;

    // SRAM models: data valid one cycle after the address.
    always @(posedge bclk) sram_if.ram_rdata  <= mem[addr[2:0]];
    always @(posedge bclk) sram_if2.ram_rdata <= mem[addr2];

    typedef struct {
        logic [17:0] end_a;
        int unsigned len;
        int unsigned frames;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One daclrc slot of len bclk; collects the 16 bits following the edge.
    task automatic slot(input logic sel, input logic lrc, input int unsigned len,
                        output logic [15:0] w, output logic zeros_ok, output logic saw_done);
        @(negedge bclk);
        daclrc   = lrc;
        w        = '0;
        zeros_ok = 1'b1;
        saw_done = 1'b0;
        for (int unsigned i = 0; i < len; i++) begin
            @(posedge bclk);
            #1;
            if (i < 16) w = {w[14:0], (sel ? dacdat2 : dacdat)};
            else if ((sel ? dacdat2 : dacdat) !== 1'b0) zeros_ok = 1'b0;
            if (i == 0) saw_done = sel ? done2 : done;
        end
    endtask

    task automatic start_play(input logic [17:0] e);
        @(negedge bclk);
        daclrc   = 1'b0;
        end_addr = e;
        play     = 1'b1;
        @(posedge bclk);
        #1;
        check("prime_rd", 32'(sram_if.ram_rd), 32'd1);
        check("prime_addr", 32'(addr), 32'd0);
        @(posedge bclk);
        #1;
        check("run_dat", 32'(dacdat), 32'd0);
    endtask

    task automatic run_play(input logic [17:0] e, input int unsigned len, input int unsigned exp_frames);
        logic [15:0] wl, wr;
        logic        zl, zr, sd, sd2;
        int unsigned frames;
        logic        got_done;
        start_play(e);
        frames   = 0;
        got_done = 1'b0;
        for (int unsigned f = 0; f <= exp_frames; f++) begin
            slot(1'b0, 1'b1, len, wl, zl, sd);
            if (sd) begin
                got_done = 1'b1;
                check("done_word", 32'(wl), 32'd0);
                break;
            end
            slot(1'b0, 1'b0, len, wr, zr, sd2);
            check($sformatf("left%0d", f), 32'(wl), 32'(mem[f[2:0]]));
            check($sformatf("right%0d", f), 32'(wr), 32'(mem[f[2:0]]));
            check($sformatf("tail_zero%0d", f), 32'(zl & zr), 32'd1);
            if (f + 1 < exp_frames) check($sformatf("addr%0d", f), 32'(addr), f + 1);
            frames++;
        end
        check("frames", frames, exp_frames);
        check("done_seen", 32'(got_done), 32'd1);
        check("done", 32'(done), 32'd1);
        check("done_rd", 32'(sram_if.ram_rd), 32'd0);
        check("done_dat", 32'(dacdat), 32'd0);
        @(negedge bclk);
        play = 1'b0;
        #1;
        check("stop_oe", 32'(sram_if.addr_oe), 32'd0);
        @(posedge bclk);
        #1;
        check("idle_done", 32'(done), 32'd0);
    endtask

    initial begin
        logic [15:0] w;
        logic        z, sd;

        mem[0] = 16'hA5C3; mem[1] = 16'h0001; mem[2] = 16'h8000; mem[3] = 16'h7FFE;
        mem[4] = 16'h1234; mem[5] = 16'hFFFF; mem[6] = 16'h0F0F; mem[7] = 16'hC001;

        vecs[0] = '{end_a: 18'd1, len: 32, frames: 2};
        vecs[1] = '{end_a: 18'd3, len: 20, frames: 4};
        vecs[2] = '{end_a: 18'd0, len: 18, frames: 1};
        vecs[3] = '{end_a: 18'd2, len: 18, frames: 3};

        // Reset held with play high.
        rst_n     = 1'b0;
        play      = 1'b1;
        play2     = 1'b0;
        daclrc    = 1'b0;
        end_addr  = '0;
        end_addr2 = 3'd7;
        for (int i = 0; i < 3; i++) begin
            @(posedge bclk);
            #1;
            check("rst_dat", 32'(dacdat), 32'd0);
            check("rst_rd", 32'(sram_if.ram_rd), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_oe", 32'(sram_if.addr_oe), 32'd0);
        end
        @(negedge bclk);
        rst_n = 1'b1;
        play  = 1'b0;
        @(posedge bclk);
        #1;
        check("idle_rd", 32'(sram_if.ram_rd), 32'd0);
        check("idle_oe", 32'(sram_if.addr_oe), 32'd0);

        for (int i = 0; i < 4; i++) begin
            run_play(vecs[i].end_a, vecs[i].len, vecs[i].frames);
        end

        // Stop in the middle of a left word, then restart from address 0.
        start_play(18'd3);
        @(negedge bclk);
        daclrc = 1'b1;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge bclk);
            #1;
            w = {w[14:0], dacdat};
        end
        check("stop_bits", 32'(w[7:0]), 32'h0A5);
        @(negedge bclk);
        play = 1'b0;
        #1;
        check("stop_oe_comb", 32'(sram_if.addr_oe), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge bclk);
            #1;
            check("stop_dat", 32'(dacdat), 32'd0);
            check("stop_rd", 32'(sram_if.ram_rd), 32'd0);
        end
        run_play(18'd1, 20, 2);

        // Reset during a right slot.
        start_play(18'd3);
        slot(1'b0, 1'b1, 20, w, z, sd);
        check("rst_left", 32'(w), 32'hA5C3);
        @(negedge bclk);
        daclrc = 1'b0;
        w = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge bclk);
            #1;
            w = {w[14:0], dacdat};
        end
        check("rst_right_bits", 32'(w[4:0]), 32'h14);
        @(negedge bclk);
        rst_n = 1'b0;
        @(posedge bclk);
        #1;
        check("midrst_dat", 32'(dacdat), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_rd", 32'(sram_if.ram_rd), 32'd0);
        @(negedge bclk);
        rst_n = 1'b1;
        play  = 1'b0;
        @(posedge bclk);
        #1;
        check("midrst_idle", 32'(sram_if.ram_rd), 32'd0);

        // All-ones end address on the 3-bit instance: addr saturates at 7.
        @(negedge bclk);
        daclrc = 1'b0;
        play2  = 1'b1;
        @(posedge bclk);
        @(posedge bclk);
        #1;
        check("sat_oe", 32'(sram_if2.addr_oe), 32'd1);
        for (int unsigned f = 0; f <= 8; f++) begin
            slot(1'b1, 1'b1, 18, w, z, sd);
            if (f == 8) begin
                check("sat_done_seen", 32'(sd), 32'd1);
                break;
            end
            check($sformatf("sat_word%0d", f), 32'(w), 32'(mem[f[2:0]]));
            check($sformatf("sat_addr%0d", f), 32'(addr2), (f < 7) ? f + 1 : 32'd7);
            slot(1'b1, 1'b0, 18, w, z, sd);
        end
        check("sat_done", 32'(done2), 32'd1);
        check("sat_rd", 32'(sram_if2.ram_rd), 32'd0);
        check("sat_addr_end", 32'(addr2), 32'd7);
        @(negedge bclk);
        play2 = 1'b0;
        @(posedge bclk);
        #1;
        check("sat_idle", 32'(done2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dac_playback.md
# dac_playback

Playback counterpart of the codec capture path. It reads 16-bit mono samples from the shared SRAM, starting at address 0 and ending at a programmed end address. It serialises each sample MSB-first onto the audio CODEC DAC data line in I2S format and sends the same sample on the left and right channels. It runs in the CODEC's bclk domain and shares the SRAM address/data bus with the capture block, so it drives the bus only while `play` is high.

## Interface
- `SAMPLE_W`, 16: sample width, in bits per channel slot.
- `ADDR_W`, 18: SRAM word address width.
- `bclk` input 1: CODEC bit clock; the only clock; all logic on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `daclrc` input 1: CODEC DAC L/R clock; 1 = left slot, 0 = right slot; sampled on `bclk`.
- `play` input 1: level request from the I2C/control side; 1 = play, 0 = stop.
- `end_addr` input ADDR_W: last valid sample address; sampled when leaving IDLE.
- `ram_rdata` input SAMPLE_W: SRAM read data; valid one cycle after `addr` is stable.
- `addr` output ADDR_W: SRAM address; high-Z when `play`=0.
- `ram_rd` output 1: read enable; 1 in PRIME and RUN only.
- `dacdat` output 1: serial data to the CODEC.
- `done` output 1: 1 while in DONE.

## Operation
- States: IDLE, PRIME, RUN, DONE.
- Registers: `addr_q`, `end_q`, `next_sample`, `sample`, `last_q`, `lrc_q` (previous `daclrc`), bit counter 0..16.
- **IDLE**
  - Holds `addr_q`=0, `dacdat`=0, `done`=0.
  - When `play`=1: latch `end_q`<=`end_addr`, go to PRIME.
- **PRIME**
  - Lasts one cycle.
  - At its closing edge: `next_sample`<=`ram_rdata` (data from address 0), go to RUN.
- **RUN, rising `daclrc` edge** (`daclrc`=1, `lrc_q`=0), left slot:
  - If `last_q`=1: go to DONE and drive `dacdat`=0.
  - Otherwise:
    - `sample`<=`next_sample`.
    - `last_q`<=(`addr_q`==`end_q`).
    - `addr_q`<=`addr_q`+1, saturating at all-ones.
    - Start shifting.
- **RUN, falling `daclrc` edge**, right slot:
  - Re-shift the same `sample`.
  - `next_sample`<=`ram_rdata`. `addr` has been stable for at least one full slot.
- **Shifting**
  - On the detect edge, `dacdat`<=`sample[15]` (the new value when loading).
  - On each of the next 15 edges, the next lower bit.
  - Then `dacdat`=0 until the next `daclrc` edge.
  - An edge that arrives mid-word aborts the word and restarts at the MSB.
- **DONE**
  - `done`=1, `dacdat`=0, `ram_rd`=0.
  - When `play`=0: go to IDLE.
- **`play`=0 in any state**: go to IDLE on the next edge. `addr` goes high-Z combinationally.
- **`end_addr`=0**: one sample plays, then DONE.
- **`end_addr`=all-ones**: the sample at all-ones plays. `addr_q` saturates and never wraps.

## Timing
- Reset (`rst_n`=0 at a rising edge) sets:
  - state IDLE;
  - `addr_q`, `sample`, `next_sample` = 0;
  - `last_q`, `lrc_q` = 0;
  - `dacdat`=0, `ram_rd`=0, `done`=0.
- Reset mid-word drops the word; `dacdat` is 0 the following cycle.
- Latency from `play`↑ to the first MSB:
  - 2 edges to reach RUN;
  - then wait for the next rising `daclrc` edge;
  - MSB is driven at that edge.
- Reset and `play`=0 take priority over a `daclrc` edge on the same cycle.
- `daclrc` edges are detected on the same cycle they are sampled. The CODEC (I2S mode) samples the MSB one `bclk` after the `daclrc` transition.
- The design requires at least 18 `bclk` per slot.

## Structure
- Shared package `audio_pkg`:
  - `SAMPLE_W` and `ADDR_W` constants;
  - `dac_state_t` enum {IDLE, PRIME, RUN, DONE}.
- One sub-module, `i2s_tx_shift`:
  - inputs: `load` pulse, 16-bit word;
  - output: `dacdat` with bit counter;
  - holds `dacdat` at 0 after 16 bits.

## Test plan
- **Reset**: `rst_n`=0 for 3 cycles with `play`=1 → all outputs 0, `addr` high-Z. Release with `play`=0 → state IDLE.
- **Basic playback**:
  - Setup: RAM[0]=16'hA5C3, RAM[1]=16'h0001, `end_addr`=1, 32 `bclk` per slot.
  - Required `dacdat`: A5C3 MSB-first in left and right, then 0001 in left and right.
  - Then `done`=1 and `dacdat`=0.
- **Address sequence**: `end_addr`=3 → `addr` steps 0,1,2,3, one step per rising `daclrc`. `ram_rd` falls in DONE. Exactly 4 frames are played.
- **Stop mid-word**: drop `play` at bit 7 of a left slot → next edge: IDLE, `dacdat`=0, `addr`=Z. A new `play` restarts at address 0.
- **Boundary**:
  - `end_addr`=0 → one frame, then DONE.
  - `end_addr`=18'h3FFFF with preset `addr_q` near the top → `addr` stops at 3FFFF and does not wrap; DONE follows.
- **Reset mid-operation**: assert `rst_n`=0 during a right slot → `dacdat`=0 on the next cycle, state IDLE, `done`=0.
